fetch_stage: RTL



---
 rtl/fetch_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory,
// buffers one fetched word and loads the IF/ID register under hazard control.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        pipe_en,
    input  logic        imem_en,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_wait,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_drop_pc;
    logic        r_drop;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic        r_buf_valid;

    logic        w_ifid_load;
    logic        w_in_wait;
    logic        w_issue;
    logic        w_complete;
    logic        w_fill;
    logic        w_park;
    logic [31:0] w_target;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_target    = branch_target & ~32'h0000_0003;
        w_ifid_load = IFIDWrite & pipe_en;
        w_in_wait   = (r_state == S_WAIT);
        w_issue     = (r_state == S_REQ) & imem_en & PCWrite & pipe_en &
                      (~r_buf_valid | w_ifid_load) & ~branch_taken;
        w_complete  = (w_issue | w_in_wait) & imem_ready;
        w_fill      = w_complete & ~r_drop & ~branch_taken;
        // A redirect while the memory is still busy is parked until that response retires.
        w_park      = branch_taken & w_in_wait & ~imem_ready;

        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = S_REQ;
            S_REQ:   if (w_issue && !imem_ready) w_state_next = S_WAIT;
            S_WAIT:  if (imem_ready) w_state_next = S_REQ;
            default: w_state_next = S_IDLE;
        endcase

        imem_req  = w_issue | w_in_wait;
        imem_addr = r_pc;
        imem_wait = w_in_wait & ~imem_ready;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_buf_valid <= 1'b0;
            ifid_instr  <= NOP_INSTR;
            ifid_pc4    <= 32'h0000_0000;
            ifid_valid  <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (branch_taken) begin
                r_buf_valid <= 1'b0;
                r_drop      <= w_park;
                if (!w_park) r_pc <= w_target;
            end else begin
                if (w_complete) begin
                    r_drop <= 1'b0;
                    r_pc   <= r_drop ? r_drop_pc : r_pc + 32'd4;
                end
                if (w_fill)
                    r_buf_valid <= 1'b1;
                else if (w_ifid_load)
                    r_buf_valid <= 1'b0;
            end

            if (w_ifid_load) begin
                if (r_buf_valid && !branch_taken) begin
                    ifid_instr <= r_buf_instr;
                    ifid_pc4   <= r_buf_pc + 32'd4;
                    ifid_valid <= 1'b1;
                end else begin
                    ifid_instr <= NOP_INSTR;
                    ifid_valid <= 1'b0;
                end
            end
        end
    end

    // NOTE: payload registers carry no reset; their valid/drop qualifiers are reset instead.
    always_ff @(posedge clock) begin
        if (w_fill) begin
            r_buf_instr <= imem_rdata;
            r_buf_pc    <= r_pc;
        end
        if (w_park) r_drop_pc <= w_target;
    end

endmodule
